// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 encryption: one round per clock on a registered 128-bit state.
// The round key for the current step is fetched via rk_idx. The result is held until out_ready.
module aes_round_engine #(
  parameter int NR       = 10,
  parameter bit STATE_IO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  generate
    if (NR != 10 && NR != 12 && NR != 14) begin : g_bad_nr
      $error("aes_round_engine: NR must be 10, 12 or 14");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(NR);

  // Forward S-box. Entry x sits at bits [8*(255-x) +: 8].
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[8*(255 - int'(x)) +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Internal state is row-major: row r, column c at byte 4*r+c counted from the MSB.
  // A FIPS byte string is column-major, so the mapping is a 4x4 transpose and its own inverse.
  function automatic logic [127:0] io_map(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int i = 0; i < 16; i++)
      t[8*(15 - (4*(i%4) + i/4)) +: 8] = s[8*(15 - i) +: 8];
    return STATE_IO ? t : s;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] t;
    t = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[8*(15 - (4*r + c)) +: 8] = sbox(s[8*(15 - (4*r + ((c + r) % 4))) +: 8]);
    return t;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a0, a1, a2, a3;
    t = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15 - c) +: 8];
      a1 = s[8*(11 - c) +: 8];
      a2 = s[8*(7 - c) +: 8];
      a3 = s[8*(3 - c) +: 8];
      t[8*(15 - c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      t[8*(11 - c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      t[8*(7 - c) +: 8]  = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      t[8*(3 - c) +: 8]  = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return t;
  endfunction

  state_t       state;
  logic [127:0] st_q;
  logic [3:0]   round_q;
  logic         idle_q;
  logic         valid_q;
  logic         busy_q;

  logic [127:0] rk_int;
  logic [127:0] sr_w;
  logic [127:0] mc_w;
  logic [127:0] round_nxt;

  always_comb begin
    rk_int    = io_map(rk_data);
    sr_w      = sub_shift(st_q);
    mc_w      = mix_columns(sr_w);
    round_nxt = ((round_q == LAST) ? sr_w : mc_w) ^ rk_int;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      st_q    <= '0;
      round_q <= '0;
      idle_q  <= 1'b1;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            st_q    <= io_map(in_data) ^ rk_int;
            round_q <= 4'd1;
            idle_q  <= 1'b0;
            busy_q  <= 1'b1;
            state   <= S_ROUND;
          end
        end
        S_ROUND: begin
          st_q <= round_nxt;
          if (round_q == LAST) begin
            valid_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            round_q <= round_q + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            idle_q  <= 1'b1;
            round_q <= '0;
            state   <= S_IDLE;
          end
        end
        default: begin
          state   <= S_IDLE;
          round_q <= '0;
          idle_q  <= 1'b1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gating by rst keeps in_ready low for the whole reset pulse, not just until the next edge.
  assign in_ready  = idle_q & ~rst;
  assign rk_idx    = round_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign out_data  = valid_q ? io_map(st_q) : '0;

endmodule
